// File: rtl/tap_ctrl.sv
// IEEE 1149.1-style TAP controller: TMS-driven state machine, instruction register,
// instruction decode, DR strobes and TDO mux. Optional debug port: TAP_STATE_DBG_EN.
module tap_ctrl #(
  parameter int unsigned          IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST   = 4'h0,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE   = 4'h1,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE   = 4'h2,
  parameter logic [IR_WIDTH-1:0] OP_INTEST   = 4'h3,
  parameter logic [IR_WIDTH-1:0] OP_USERCODE = 4'h4,
  parameter logic [IR_WIDTH-1:0] OP_RUNBIST  = 4'h5,
  parameter logic [IR_WIDTH-1:0] OP_GETTEST  = 4'h6
) (
  input  logic TCK,
  input  logic TRST_N,
  input  logic TMS,
  input  logic TDI,
  output logic TDO,
  output logic TDO_EN,
  output logic CAPTUREDR,
  output logic SHIFTDR,
  output logic UPDATEDR,
  output logic IDCODE_SELECT,
  output logic EXTEST_SELECT,
  output logic SAMPLE_SELECT,
  output logic INTEST_SELECT,
  output logic USERCODE_SELECT,
  output logic RUNBIST_SELECT,
  output logic GETTEST_SELECT,
  input  logic ID_REG_TDO,
  input  logic USERCODE_REG_TDO,
  input  logic BSR_TDO,
  input  logic STATUS_BIST_REG_TDO
`ifdef TAP_STATE_DBG_EN
  ,
  output logic [3:0] STATE_DBG
`endif
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
    SHDR  = 4'h2, EX1DR = 4'h1, PDR   = 4'h3, EX2DR = 4'h0,
    UPDR  = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA,
    EX1IR = 4'h9, PIR   = 4'hB, EX2IR = 4'h8, UPIR  = 4'hD
  } tap_state_e;

  tap_state_e          state_r;
  tap_state_e          state_next_s;
  logic [IR_WIDTH-1:0] ir_shift_r;
  logic [IR_WIDTH-1:0] ir_latch_r;
  logic                bypass_r;
  logic                tdo_r;
  logic                tdo_en_r;
  logic                tdo_mux_s;
  logic                unused_usercode_s;

  // The BSR carries the usercode path, so this serial input has no sink here.
  assign unused_usercode_s = USERCODE_REG_TDO;

  // Next-state function of the 1149.1 TAP graph.
  always_comb begin
    state_next_s = TLR;
    case (state_r)
      TLR:     state_next_s = TMS ? TLR   : RTI;
      RTI:     state_next_s = TMS ? SELDR : RTI;
      SELDR:   state_next_s = TMS ? SELIR : CAPDR;
      CAPDR:   state_next_s = TMS ? EX1DR : SHDR;
      SHDR:    state_next_s = TMS ? EX1DR : SHDR;
      EX1DR:   state_next_s = TMS ? UPDR  : PDR;
      PDR:     state_next_s = TMS ? EX2DR : PDR;
      EX2DR:   state_next_s = TMS ? UPDR  : SHDR;
      UPDR:    state_next_s = TMS ? SELDR : RTI;
      SELIR:   state_next_s = TMS ? TLR   : CAPIR;
      CAPIR:   state_next_s = TMS ? EX1IR : SHIR;
      SHIR:    state_next_s = TMS ? EX1IR : SHIR;
      EX1IR:   state_next_s = TMS ? UPIR  : PIR;
      PIR:     state_next_s = TMS ? EX2IR : PIR;
      EX2IR:   state_next_s = TMS ? UPIR  : SHIR;
      UPIR:    state_next_s = TMS ? SELDR : RTI;
      default: state_next_s = TLR;
    endcase
  end

  // State, instruction register stages and bypass bit.
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_r    <= TLR;
      ir_shift_r <= IR_CAPTURE;
      ir_latch_r <= OP_IDCODE;
      bypass_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        CAPIR:   ir_shift_r <= IR_CAPTURE;
        SHIR:    ir_shift_r <= {TDI, ir_shift_r[IR_WIDTH-1:1]};
        default: ir_shift_r <= ir_shift_r;
      endcase
      // Forced on the edge that enters TLR too, so IDCODE is selected as soon as TLR is reached.
      if (state_next_s == TLR) begin
        ir_latch_r <= OP_IDCODE;
      end else if (state_r == UPIR) begin
        ir_latch_r <= ir_shift_r;
      end else begin
        ir_latch_r <= ir_latch_r;
      end
      case (state_r)
        CAPDR:   bypass_r <= 1'b0;
        SHDR:    bypass_r <= TDI;
        default: bypass_r <= bypass_r;
      endcase
    end
  end

  // Instruction decode from the latched IR only; unknown opcodes select nothing.
  always_comb begin
    IDCODE_SELECT   = 1'b0;
    EXTEST_SELECT   = 1'b0;
    SAMPLE_SELECT   = 1'b0;
    INTEST_SELECT   = 1'b0;
    USERCODE_SELECT = 1'b0;
    RUNBIST_SELECT  = 1'b0;
    GETTEST_SELECT  = 1'b0;
    case (ir_latch_r)
      OP_IDCODE:   IDCODE_SELECT   = 1'b1;
      OP_EXTEST:   EXTEST_SELECT   = 1'b1;
      OP_SAMPLE:   SAMPLE_SELECT   = 1'b1;
      OP_INTEST:   INTEST_SELECT   = 1'b1;
      OP_USERCODE: USERCODE_SELECT = 1'b1;
      OP_RUNBIST:  RUNBIST_SELECT  = 1'b1;
      OP_GETTEST:  GETTEST_SELECT  = 1'b1;
      default:     IDCODE_SELECT   = 1'b0;
    endcase
  end

  // Serial source feeding TDO for the current shift state.
  always_comb begin
    tdo_mux_s = tdo_r;
    if (state_r == SHIR) begin
      tdo_mux_s = ir_shift_r[0];
    end else if (IDCODE_SELECT) begin
      tdo_mux_s = ID_REG_TDO;
    end else if (SAMPLE_SELECT || EXTEST_SELECT || INTEST_SELECT ||
                 USERCODE_SELECT || GETTEST_SELECT) begin
      tdo_mux_s = BSR_TDO;
    end else if (RUNBIST_SELECT) begin
      tdo_mux_s = STATUS_BIST_REG_TDO;
    end else begin
      tdo_mux_s = bypass_r;
    end
  end

  // TDO and its enable launch on the falling edge; TDO holds outside shift states.
  always_ff @(negedge TCK) begin
    if (!TRST_N) begin
      tdo_r    <= 1'b0;
      tdo_en_r <= 1'b0;
    end else if (state_r == SHIR || state_r == SHDR) begin
      tdo_r    <= tdo_mux_s;
      tdo_en_r <= 1'b1;
    end else begin
      tdo_r    <= tdo_r;
      tdo_en_r <= 1'b0;
    end
  end

  assign TDO       = tdo_r;
  assign TDO_EN    = tdo_en_r;
  assign CAPTUREDR = (state_r == CAPDR);
  assign SHIFTDR   = (state_r == SHDR);
  assign UPDATEDR  = (state_r == UPDR);

`ifdef TAP_STATE_DBG_EN
  assign STATE_DBG = state_r;
`endif

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl: reset, IR capture/shift/update, decode, DR strobes,
// TDO source selection, bypass delay, TMS-driven return to TLR and reset mid-shift.
module tb_tap_ctrl;

  logic TCK, TRST_N, TMS, TDI;
  logic TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR;
  logic IDCODE_SELECT, EXTEST_SELECT, SAMPLE_SELECT, INTEST_SELECT;
  logic USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT;
  logic ID_REG_TDO, USERCODE_REG_TDO, BSR_TDO, STATUS_BIST_REG_TDO;
`ifdef TAP_STATE_DBG_EN
  logic [3:0] state_dbg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] SEL_ID   = 8'h02;
  localparam logic [7:0] SEL_USER = 8'h10;
  localparam logic [7:0] SEL_BIST = 8'h20;
  localparam logic [7:0] SEL_NONE = 8'h00;
  localparam logic [7:0] ST_NONE  = 8'h00;
  localparam logic [7:0] ST_CAP   = 8'h04;
  localparam logic [7:0] ST_SHIFT = 8'h02;
  localparam logic [7:0] ST_UPD   = 8'h01;

  // Bit n of sel_v is the select for opcode n.
  logic [7:0] sel_v;
  logic [7:0] strobe_v;
  assign sel_v = {1'b0, GETTEST_SELECT, RUNBIST_SELECT, USERCODE_SELECT,
                  INTEST_SELECT, SAMPLE_SELECT, IDCODE_SELECT, EXTEST_SELECT};
  assign strobe_v = {5'b00000, CAPTUREDR, SHIFTDR, UPDATEDR};

  tap_ctrl dut (
    .TCK                 (TCK),
    .TRST_N              (TRST_N),
    .TMS                 (TMS),
    .TDI                 (TDI),
    .TDO                 (TDO),
    .TDO_EN              (TDO_EN),
    .CAPTUREDR           (CAPTUREDR),
    .SHIFTDR             (SHIFTDR),
    .UPDATEDR            (UPDATEDR),
    .IDCODE_SELECT       (IDCODE_SELECT),
    .EXTEST_SELECT       (EXTEST_SELECT),
    .SAMPLE_SELECT       (SAMPLE_SELECT),
    .INTEST_SELECT       (INTEST_SELECT),
    .USERCODE_SELECT     (USERCODE_SELECT),
    .RUNBIST_SELECT      (RUNBIST_SELECT),
    .GETTEST_SELECT      (GETTEST_SELECT),
    .ID_REG_TDO          (ID_REG_TDO),
    .USERCODE_REG_TDO    (USERCODE_REG_TDO),
    .BSR_TDO             (BSR_TDO),
`ifdef TAP_STATE_DBG_EN
    .STATE_DBG           (state_dbg),
`endif
    .STATUS_BIST_REG_TDO (STATUS_BIST_REG_TDO)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive TMS/TDI, take one rising edge, settle.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge TCK);
    #1;
  endtask

  // RTI -> IR scan of val -> RTI, checking captured bits on TDO and select stability.
  task automatic load_ir(input logic [3:0] val, input logic [7:0] prev_sel);
    logic [3:0] cap;
    cap = 4'b0001;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("ir_tdo", {7'b0000000, TDO}, {7'b0000000, cap[i]});
      check("ir_tdo_en", {7'b0000000, TDO_EN}, 8'h01);
      check("ir_sel_hold", sel_v, prev_sel);
      step((i == 3) ? 1'b1 : 1'b0, val[i]);
    end
    step(1'b1, 1'b0);
    check("upir_sel_hold", sel_v, prev_sel);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] tdi_seq;
    logic [3:0] tdo_exp;
    logic [3:0] ops [4];
    logic [7:0] prev;
    tdi_seq = 4'b1101;
    tdo_exp = 4'b1010;
    ops = '{4'h0, 4'h2, 4'h3, 4'h6};
    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0;
    ID_REG_TDO = 1'b0; USERCODE_REG_TDO = 1'b0; BSR_TDO = 1'b0; STATUS_BIST_REG_TDO = 1'b0;

    // Reset
    step(1'b1, 1'b0);
    at_neg();
    check("rst_tdo_en", {7'b0000000, TDO_EN}, 8'h00);
    check("rst_tdo", {7'b0000000, TDO}, 8'h00);
    check("rst_sel", sel_v, SEL_ID);
    check("rst_strobe", strobe_v, ST_NONE);
    TRST_N = 1'b1;
    step(1'b1, 1'b0);
    check("tlr_sel", sel_v, SEL_ID);

    // IDCODE DR scan: ID register drives TDO, then TDO holds after leaving SHDR
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("id_capdr", strobe_v, ST_CAP);
    step(1'b0, 1'b0);
    check("id_shdr", strobe_v, ST_SHIFT);
    at_neg();
    check("id_tdo0", {7'b0000000, TDO}, 8'h00);
    ID_REG_TDO = 1'b1;
    step(1'b0, 1'b0);
    at_neg();
    check("id_tdo1", {7'b0000000, TDO}, 8'h01);
    ID_REG_TDO = 1'b0;
    step(1'b1, 1'b0);
    check("id_ex1dr", strobe_v, ST_NONE);
    at_neg();
    check("hold_tdo", {7'b0000000, TDO}, 8'h01);
    check("hold_tdo_en", {7'b0000000, TDO_EN}, 8'h00);
    step(1'b1, 1'b0);
    check("id_updr", strobe_v, ST_UPD);
    step(1'b0, 1'b0);
    check("id_rti", strobe_v, ST_NONE);

    // USERCODE load, then DR scan through BSR with 3 shift cycles
    load_ir(4'h4, SEL_ID);
    check("user_sel", sel_v, SEL_USER);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("user_capdr", strobe_v, ST_CAP);
    step(1'b0, 1'b0);
    check("user_shdr1", strobe_v, ST_SHIFT);
    BSR_TDO = 1'b1;
    at_neg();
    check("user_tdo1", {7'b0000000, TDO}, 8'h01);
    BSR_TDO = 1'b0;
    step(1'b0, 1'b0);
    at_neg();
    check("user_tdo0", {7'b0000000, TDO}, 8'h00);
    step(1'b0, 1'b0);
    check("user_shdr3", strobe_v, ST_SHIFT);
    step(1'b1, 1'b0);
    check("user_ex1dr", strobe_v, ST_NONE);
    step(1'b1, 1'b0);
    check("user_updr", strobe_v, ST_UPD);
    step(1'b0, 1'b0);
    check("user_rti", strobe_v, ST_NONE);

    // Unknown opcode routes the one-bit bypass
    load_ir(4'h9, SEL_USER);
    check("unk_sel", sel_v, SEL_NONE);
    ID_REG_TDO = 1'b1; BSR_TDO = 1'b1; STATUS_BIST_REG_TDO = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("bypass_tdo", {7'b0000000, TDO}, {7'b0000000, tdo_exp[i]});
      step(1'b0, tdi_seq[i]);
    end
    ID_REG_TDO = 1'b0; BSR_TDO = 1'b0; STATUS_BIST_REG_TDO = 1'b0;

    // Five TMS=1 clocks from SHDR return to TLR and re-select IDCODE
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("tms4_sel", sel_v, SEL_NONE);
    step(1'b1, 1'b0);
    check("tms5_sel", sel_v, SEL_ID);
    check("tms5_strobe", strobe_v, ST_NONE);
    step(1'b0, 1'b0);

    // RUNBIST routes the BIST status register
    load_ir(4'h5, SEL_ID);
    check("bist_sel", sel_v, SEL_BIST);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    STATUS_BIST_REG_TDO = 1'b1;
    at_neg();
    check("bist_tdo1", {7'b0000000, TDO}, 8'h01);
    STATUS_BIST_REG_TDO = 1'b0;
    step(1'b0, 1'b0);
    at_neg();
    check("bist_tdo0", {7'b0000000, TDO}, 8'h00);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Reset in the middle of an IR shift
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    TRST_N = 1'b0;
    step(1'b0, 1'b0);
    check("mid_rst_sel", sel_v, SEL_ID);
    check("mid_rst_strobe", strobe_v, ST_NONE);
    at_neg();
    check("mid_rst_tdo", {7'b0000000, TDO}, 8'h00);
    check("mid_rst_tdo_en", {7'b0000000, TDO_EN}, 8'h00);
    TRST_N = 1'b1;
    step(1'b0, 1'b0);
    check("post_rst_strobe", strobe_v, ST_NONE);

    // Remaining opcodes decode one-hot
    prev = SEL_ID;
    for (int k = 0; k < 4; k++) begin
      load_ir(ops[k], prev);
      prev = 8'h01 << ops[k];
      check("op_sel", sel_v, prev);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
